// File: rtl/mul_bus_pkg.sv
// Shared definitions for the multiplier bus master: slave address map,
// FSM state encoding and the operand-pair clamp helper.
package mul_bus_pkg;

    localparam logic [7:0] ADDR_CAND  = 8'h00;
    localparam logic [7:0] ADDR_LIER  = 8'h01;
    localparam logic [7:0] ADDR_START = 8'h02;
    localparam logic [7:0] ADDR_CLEAR = 8'h03;
    localparam logic [7:0] ADDR_INTEN = 8'h04;
    localparam logic [7:0] ADDR_RES   = 8'h10;
    localparam int         MAX_PAIRS  = 8;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        CLEAR,
        INTEN,
        MRD,
        MWAIT,
        BWR,
        START,
        WAIT_INT,
        BRD,
        BWAIT,
        MEMWR,
        RELEASE
    } state_t;

    // The multiplier FIFO cannot hold more than MAX_PAIRS operand pairs.
    function automatic logic [3:0] clamp_pairs(input logic [3:0] n);
        return (n > 4'(MAX_PAIRS)) ? 4'(MAX_PAIRS) : n;
    endfunction

endpackage

// File: rtl/mul_bus_if.sv
// System-bus and data-RAM signal bundle between the bus master and its
// environment (arbiter/multiplier slave and shared RAM).
interface mul_bus_if;

    logic        M_req;
    logic        M_grant;
    logic        M_wr;
    logic [7:0]  M_address;
    logic [31:0] M_dout;
    logic [31:0] M_din;
    logic        m_interrupt;
    logic        mem_cs;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output M_req, M_wr, M_address, M_dout,
        input  M_grant, M_din, m_interrupt,
        output mem_cs, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  M_req, M_wr, M_address, M_dout,
        output M_grant, M_din, m_interrupt,
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mul_bus_master_cnt.sv
// Word index counter shared by the operand and result phases:
// synchronous clear, increment, and terminal-count flag.
module mul_bus_master_cnt (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       inc,
    input  logic [4:0] term,
    output logic [4:0] value,
    output logic       last
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            value <= 5'd0;
        else if (clear)
            value <= 5'd0;
        else if (inc)
            value <= value + 5'd1;
    end

    assign last = (value == term);

endmodule

// File: rtl/mul_bus_master.sv
// Bus master that streams operand pairs from RAM into the multiplier slave,
// starts it, waits for its interrupt and copies the results back to RAM.
module mul_bus_master
    import mul_bus_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_start,
    input  logic [3:0] cmd_count,
    input  logic [7:0] cmd_src,
    input  logic [7:0] cmd_dst,
    output logic       busy,
    output logic       done,
    mul_bus_if.master  bus
);

    state_t     state;
    logic [7:0] src_r;
    logic [7:0] dst_r;
    logic [4:0] term_r;
    logic [3:0] pairs;
    logic [4:0] cnt;
    logic       cnt_last;
    logic       cnt_clear;
    logic       cnt_inc;

    assign pairs = clamp_pairs(cmd_count);

    // The index restarts at the first operand read and at the first result read.
    always_comb begin
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        if (state == INTEN && bus.M_grant)
            cnt_clear = 1'b1;
        if (state == WAIT_INT && bus.m_interrupt)
            cnt_clear = 1'b1;
        if (state == BWR && bus.M_grant)
            cnt_inc = 1'b1;
        if (state == MEMWR)
            cnt_inc = 1'b1;
    end

    mul_bus_master_cnt u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .term    (term_r),
        .value   (cnt),
        .last    (cnt_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            src_r         <= 8'd0;
            dst_r         <= 8'd0;
            term_r        <= 5'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.M_req     <= 1'b0;
            bus.M_wr      <= 1'b0;
            bus.M_address <= 8'd0;
            bus.M_dout    <= 32'd0;
            bus.mem_cs    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 8'd0;
            bus.mem_wdata <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cmd_start) begin
                    src_r  <= cmd_src;
                    dst_r  <= cmd_dst;
                    term_r <= {pairs, 1'b0} - 5'd1;
                    busy   <= 1'b1;
                    if (pairs == 4'd0) begin
                        done  <= 1'b1;
                        state <= RELEASE;
                    end else begin
                        bus.M_req <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: if (bus.M_grant) begin
                    bus.M_wr      <= 1'b1;
                    bus.M_address <= ADDR_CLEAR;
                    bus.M_dout    <= 32'd1;
                    state         <= CLEAR;
                end
                CLEAR: if (bus.M_grant) begin
                    bus.M_address <= ADDR_INTEN;
                    state         <= INTEN;
                end
                INTEN: if (bus.M_grant) begin
                    bus.M_wr     <= 1'b0;
                    bus.mem_cs   <= 1'b1;
                    bus.mem_we   <= 1'b0;
                    bus.mem_addr <= src_r;
                    state        <= MRD;
                end
                MRD: begin
                    bus.mem_cs <= 1'b0;
                    state      <= MWAIT;
                end
                MWAIT: begin
                    bus.M_dout    <= bus.mem_rdata;
                    bus.M_wr      <= 1'b1;
                    bus.M_address <= cnt[0] ? ADDR_LIER : ADDR_CAND;
                    state         <= BWR;
                end
                BWR: if (bus.M_grant) begin
                    if (cnt_last) begin
                        bus.M_address <= ADDR_START;
                        bus.M_dout    <= 32'd1;
                        state         <= START;
                    end else begin
                        bus.M_wr     <= 1'b0;
                        bus.mem_cs   <= 1'b1;
                        bus.mem_addr <= bus.mem_addr + 8'd1;
                        state        <= MRD;
                    end
                end
                // M_address is left at ADDR_START while the multiplier runs.
                START: if (bus.M_grant) begin
                    bus.M_wr   <= 1'b0;
                    bus.M_dout <= 32'd0;
                    state      <= WAIT_INT;
                end
                WAIT_INT: if (bus.m_interrupt) begin
                    bus.M_address <= ADDR_RES;
                    state         <= BRD;
                end
                BRD: if (bus.M_grant) begin
                    state <= BWAIT;
                end
                BWAIT: begin
                    bus.mem_cs    <= 1'b1;
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= dst_r + 8'(cnt);
                    bus.mem_wdata <= bus.M_din;
                    state         <= MEMWR;
                end
                MEMWR: begin
                    bus.mem_cs <= 1'b0;
                    bus.mem_we <= 1'b0;
                    if (cnt_last) begin
                        bus.M_req <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        bus.M_address <= ADDR_RES + 8'(cnt) + 8'd1;
                        state         <= BRD;
                    end
                end
                RELEASE: begin
                    busy      <= 1'b0;
                    bus.M_req <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_bus_master.sv
// Directed bench for mul_bus_master with a behavioural multiplier slave,
// grant-controlled arbiter and synchronous RAM.
module tb_mul_bus_master;
    import mul_bus_pkg::*;

    typedef struct {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [31:0] cand;
        logic [31:0] lier;
        logic [31:0] lo;
        logic [31:0] hi;
        int          irq_delay;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_start = 1'b0;
    logic [3:0] cmd_count = 4'd0;
    logic [7:0] cmd_src = 8'd0;
    logic [7:0] cmd_dst = 8'd0;
    logic       busy;
    logic       done;
    logic       grant_en = 1'b1;

    mul_bus_if bus();

    assign bus.M_grant = bus.M_req & grant_en;

    mul_bus_master dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_start (cmd_start),
        .cmd_count (cmd_count),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    logic [31:0] res [16];
    logic [31:0] cand_q [$];
    logic [31:0] lier_q [$];
    logic [7:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [7:0]  rd_addr_q [$];
    logic [63:0] prod;
    logic        inten = 1'b0;
    int          irq_delay = 3;
    int          irq_cnt = 0;
    int          done_cnt = 0;
    int          req_cyc = 0;
    int          cs_cyc = 0;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    // Multiplier slave: operand FIFOs, result file and a delayed level interrupt.
    always @(posedge clk) begin
        bus.M_din <= res[bus.M_address[3:0]];
        if (irq_cnt != 0) begin
            irq_cnt <= irq_cnt - 1;
            if (irq_cnt == 1)
                bus.m_interrupt <= inten;
        end
        if (bus.M_grant && bus.M_wr) begin
            wr_addr_q.push_back(bus.M_address);
            wr_data_q.push_back(bus.M_dout);
            case (bus.M_address)
                ADDR_CAND:  cand_q.push_back(bus.M_dout);
                ADDR_LIER:  lier_q.push_back(bus.M_dout);
                ADDR_INTEN: inten <= 1'b1;
                ADDR_CLEAR: begin
                    cand_q.delete();
                    lier_q.delete();
                    irq_cnt         <= 0;
                    bus.m_interrupt <= 1'b0;
                end
                ADDR_START: begin
                    for (int i = 0; i < cand_q.size() && i < lier_q.size() && i < 8; i++) begin
                        prod = 64'(cand_q[i]) * 64'(lier_q[i]);
                        res[2*i]   = prod[31:0];
                        res[2*i+1] = prod[63:32];
                    end
                    cand_q.delete();
                    lier_q.delete();
                    if (irq_delay == 0)
                        bus.m_interrupt <= inten;
                    else
                        irq_cnt <= irq_delay;
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_we)
                mem[bus.mem_addr] = bus.mem_wdata;
            else begin
                bus.mem_rdata <= mem[bus.mem_addr];
                rd_addr_q.push_back(bus.mem_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (done)       done_cnt++;
        if (bus.M_req)  req_cyc++;
        if (bus.mem_cs) cs_cyc++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"},      32'(busy),          32'd0);
        checkOutput({tag, "_done"},      32'(done),          32'd0);
        checkOutput({tag, "_M_req"},     32'(bus.M_req),     32'd0);
        checkOutput({tag, "_M_wr"},      32'(bus.M_wr),      32'd0);
        checkOutput({tag, "_M_address"}, 32'(bus.M_address), 32'd0);
        checkOutput({tag, "_M_dout"},    bus.M_dout,         32'd0);
        checkOutput({tag, "_mem_cs"},    32'(bus.mem_cs),    32'd0);
        checkOutput({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        checkOutput({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        checkOutput({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
    endtask

    task automatic applyStimulus(input logic [3:0] n, input logic [7:0] src, input logic [7:0] dst);
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        done_cnt  = 0;
        req_cyc   = 0;
        cs_cyc    = 0;
        cmd_count = n;
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic waitDone(input string name, input bit drop_bwr, input bit drop_brd, output int busy_low);
        int cyc;
        bit d1;
        bit d2;
        cyc = 0;
        d1 = 1'b0;
        d2 = 1'b0;
        busy_low = 0;
        while (!done && cyc < 3000) begin
            if (drop_bwr && !d1 && bus.M_wr && bus.M_address == ADDR_LIER) begin
                d1 = 1'b1;
                grant_en = 1'b0;
                repeat (3) @(negedge clk);
                grant_en = 1'b1;
                cyc += 3;
            end else if (drop_brd && !d2 && bus.M_req && !bus.M_wr && bus.M_address == ADDR_RES + 8'd2) begin
                d2 = 1'b1;
                grant_en = 1'b0;
                repeat (3) @(negedge clk);
                grant_en = 1'b1;
                cyc += 3;
            end else begin
                if (!busy) busy_low++;
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput({name, "_done_seen"}, 32'(done), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    vec_t       vecs [6];
    int         busy_low;
    int         cyc;
    logic [7:0] a;

    initial begin
        vecs[0] = '{8'h00, 8'h08, 32'd3,          32'd5,          32'd15,         32'd0,          3};
        vecs[1] = '{8'h20, 8'h30, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE,   32'd1,          3};
        vecs[2] = '{8'h40, 8'h50, 32'h00010000,   32'h00010000,   32'd0,          32'd1,          5};
        vecs[3] = '{8'h60, 8'h70, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'hFFFFFFFE,   3};
        vecs[4] = '{8'h80, 8'h90, 32'h12345678,   32'd0,          32'd0,          32'd0,          2};
        vecs[5] = '{8'hA0, 8'hB0, 32'd7,          32'd6,          32'd42,         32'd0,          0};

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        for (int i = 0; i < 16; i++)  res[i] = 32'd0;

        repeat (2) @(negedge clk);
        checkIdle("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Single-pair commands from the vector table.
        for (int v = 0; v < 6; v++) begin
            mem[vecs[v].src]         = vecs[v].cand;
            mem[vecs[v].src + 8'd1]  = vecs[v].lier;
            mem[vecs[v].dst]         = 32'hDEADBEEF;
            mem[vecs[v].dst + 8'd1]  = 32'hDEADBEEF;
            irq_delay = vecs[v].irq_delay;
            applyStimulus(4'd1, vecs[v].src, vecs[v].dst);
            waitDone($sformatf("vec%0d", v), 1'b0, 1'b0, busy_low);
            checkOutput($sformatf("vec%0d_lo", v),        mem[vecs[v].dst],        vecs[v].lo);
            checkOutput($sformatf("vec%0d_hi", v),        mem[vecs[v].dst + 8'd1], vecs[v].hi);
            checkOutput($sformatf("vec%0d_done_cnt", v),  32'(done_cnt),           32'd1);
            checkOutput($sformatf("vec%0d_wr_cnt", v),    32'(wr_addr_q.size()),   32'd5);
            checkOutput($sformatf("vec%0d_cand_addr", v), 32'(wr_addr_q[2]),       32'(ADDR_CAND));
            checkOutput($sformatf("vec%0d_cand", v),      wr_data_q[2],            vecs[v].cand);
            checkOutput($sformatf("vec%0d_lier", v),      wr_data_q[3],            vecs[v].lier);
            checkOutput($sformatf("vec%0d_start", v),     32'(wr_addr_q[4]),       32'(ADDR_START));
        end

        // Eight pairs: cand = i+1, lier = all ones.
        irq_delay = 3;
        for (int i = 0; i < 8; i++) begin
            a = 8'hC0 + 8'(2 * i);
            mem[a]        = 32'(i + 1);
            mem[a + 8'd1] = 32'hFFFFFFFF;
        end
        for (int i = 0; i < 16; i++) mem[i] = 32'hDEADBEEF;
        applyStimulus(4'd8, 8'hC0, 8'h00);
        waitDone("pairs8", 1'b0, 1'b0, busy_low);
        checkOutput("pairs8_busy_low", 32'(busy_low), 32'd0);
        checkOutput("pairs8_done_cnt", 32'(done_cnt), 32'd1);
        checkOutput("pairs8_wr_cnt",   32'(wr_addr_q.size()), 32'd19);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("pairs8_lo%0d", i), mem[2*i],   32'd0 - 32'(i + 1));
            checkOutput($sformatf("pairs8_hi%0d", i), mem[2*i+1], 32'(i));
        end

        // Count above the FIFO depth is clamped to eight pairs.
        for (int i = 8'h60; i < 8'h72; i++) mem[i] = 32'hDEADBEEF;
        applyStimulus(4'd15, 8'hC0, 8'h60);
        waitDone("clamp", 1'b0, 1'b0, busy_low);
        checkOutput("clamp_wr_cnt", 32'(wr_addr_q.size()), 32'd19);
        checkOutput("clamp_lo7",    mem[8'h6E], 32'hFFFFFFF8);
        checkOutput("clamp_hi7",    mem[8'h6F], 32'd7);
        checkOutput("clamp_beyond", mem[8'h70], 32'hDEADBEEF);

        // Grant withdrawn for three cycles in a BWR and in a BRD.
        mem[8'h10] = 32'd10;
        mem[8'h11] = 32'd20;
        mem[8'h12] = 32'h100;
        mem[8'h13] = 32'h100;
        for (int i = 8'h20; i < 8'h24; i++) mem[i] = 32'hDEADBEEF;
        applyStimulus(4'd2, 8'h10, 8'h20);
        waitDone("grant", 1'b1, 1'b1, busy_low);
        checkOutput("grant_wr_cnt", 32'(wr_addr_q.size()), 32'd7);
        checkOutput("grant_lier0",  wr_data_q[3], 32'd20);
        checkOutput("grant_cand1",  wr_data_q[4], 32'h100);
        checkOutput("grant_start",  32'(wr_addr_q[6]), 32'(ADDR_START));
        checkOutput("grant_cs_cyc", 32'(cs_cyc), 32'd8);
        checkOutput("grant_r0",     mem[8'h20], 32'd200);
        checkOutput("grant_r1",     mem[8'h21], 32'd0);
        checkOutput("grant_r2",     mem[8'h22], 32'h10000);
        checkOutput("grant_r3",     mem[8'h23], 32'd0);

        // Zero pairs: single done/busy cycle and no traffic.
        applyStimulus(4'd0, 8'h00, 8'h00);
        checkOutput("n0_done", 32'(done), 32'd1);
        checkOutput("n0_busy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("n0_done_fall", 32'(done), 32'd0);
        checkOutput("n0_busy_fall", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("n0_req_cyc",  32'(req_cyc),  32'd0);
        checkOutput("n0_cs_cyc",   32'(cs_cyc),   32'd0);
        checkOutput("n0_done_cnt", 32'(done_cnt), 32'd1);

        // Operand addresses wrap from 0xFF to 0x00.
        mem[8'hFE] = 32'd2;
        mem[8'hFF] = 32'd3;
        mem[8'h00] = 32'd4;
        mem[8'h01] = 32'd5;
        for (int i = 8'h40; i < 8'h44; i++) mem[i] = 32'hDEADBEEF;
        applyStimulus(4'd2, 8'hFE, 8'h40);
        waitDone("wrap", 1'b0, 1'b0, busy_low);
        checkOutput("wrap_rd_cnt", 32'(rd_addr_q.size()), 32'd4);
        checkOutput("wrap_rd0",    32'(rd_addr_q[0]), 32'h0FE);
        checkOutput("wrap_rd1",    32'(rd_addr_q[1]), 32'h0FF);
        checkOutput("wrap_rd2",    32'(rd_addr_q[2]), 32'h000);
        checkOutput("wrap_rd3",    32'(rd_addr_q[3]), 32'h001);
        checkOutput("wrap_r0",     mem[8'h40], 32'd6);
        checkOutput("wrap_r1",     mem[8'h41], 32'd0);
        checkOutput("wrap_r2",     mem[8'h42], 32'd20);
        checkOutput("wrap_r3",     mem[8'h43], 32'd0);

        // Re-pulse while busy, then reset during WAIT_INT with a late interrupt pending.
        mem[8'h30] = 32'd9;
        mem[8'h31] = 32'd11;
        mem[8'h50] = 32'hDEADBEEF;
        mem[8'h51] = 32'hDEADBEEF;
        mem[8'hE0] = 32'hDEADBEEF;
        irq_delay = 40;
        applyStimulus(4'd1, 8'h30, 8'h50);
        cyc = 0;
        while (!(bus.M_req && !bus.M_wr && bus.M_address == ADDR_START) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("midrst_wait_int_reached", 32'(cyc < 200), 32'd1);
        cmd_count = 4'd3;
        cmd_dst   = 8'hE0;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        checkOutput("midrst_busy_kept", 32'(busy), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkIdle("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        irq_delay = 3;
        applyStimulus(4'd1, 8'h30, 8'h50);
        waitDone("after_rst", 1'b0, 1'b0, busy_low);
        checkOutput("after_rst_lo",       mem[8'h50], 32'd99);
        checkOutput("after_rst_hi",       mem[8'h51], 32'd0);
        checkOutput("after_rst_ignored",  mem[8'hE0], 32'hDEADBEEF);
        checkOutput("after_rst_done_cnt", 32'(done_cnt), 32'd1);
        checkOutput("after_rst_wr_cnt",   32'(wr_addr_q.size()), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
